// File: rtl/input_stream_feeder.sv
// Systolic input loader: fetches x from memory and h from the cell output stream into
// one [x | h] buffer, then streams it to P skewed PE lanes for a programmable pass count.
module input_stream_feeder #(
  parameter int ELEMENT_BITS = 8,
  parameter int X_LEN        = 4,
  parameter int H_LEN        = 4,
  parameter int P            = 4,  // must be >= 2
  parameter int ADDR_BITS    = 4,
  parameter int PASS_BITS    = 4
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [ADDR_BITS-1:0]      x_base_addr,
  output logic [ADDR_BITS-1:0]      main_mem_address_out,
  output logic                      main_mem_oe_out,
  input  logic [ELEMENT_BITS-1:0]   main_mem_data_out,
  input  logic                      cell_valid_in,
  input  logic [ELEMENT_BITS-1:0]   cell_out_data_in,
  output logic                      load_done,
  input  logic                      start,
  input  logic [PASS_BITS-1:0]      num_passes,
  output logic [P*ELEMENT_BITS-1:0] pe_data_out,
  output logic [P-1:0]              pe_valid_out,
  output logic                      busy,
  output logic                      stream_done,
  output logic                      cmd_err
);
  localparam int VEC_LEN = X_LEN + H_LEN;
  localparam int IDX_W   = $clog2(VEC_LEN);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD_H, STREAM} state_t;

  state_t                       state_q;
  logic [ADDR_BITS-1:0]         addr_q;
  logic                         oe_q, cap_vld_q, loaded_q;
  logic [IDX_W-1:0]             fcnt_q, cap_idx_q, hcnt_q, e_q;
  logic                         load_done_q, cmd_err_q, done_q, issue_q;
  logic [PASS_BITS-1:0]         pcnt_q, passes_q, passes_d;
  logic [ELEMENT_BITS-1:0]      buf_q [VEC_LEN];
  logic [P-2:0]                 vld_pipe_q, lst_pipe_q;
  logic [P-2:0][ELEMENT_BITS-1:0] dat_pipe_q;
  logic [P-1:0]                 lane_vld, lane_lst;
  logic [P-1:0][ELEMENT_BITS-1:0] lane_dat;
  logic                         src_lst;

  assign passes_d = (num_passes == '0) ? PASS_BITS'(1) : num_passes;
  // Tags the final element of the final pass so it can be tracked down the skew chain.
  assign src_lst  = issue_q && (e_q == IDX_W'(VEC_LEN-1)) &&
                    (pcnt_q == passes_q - PASS_BITS'(1));

  always_comb begin
    lane_vld    = '0;
    lane_lst    = '0;
    lane_dat    = '0;
    lane_vld[0] = issue_q;
    lane_lst[0] = src_lst;
    lane_dat[0] = issue_q ? buf_q[e_q] : '0;
    for (int k = 1; k < P; k++) begin
      lane_vld[k] = vld_pipe_q[k-1];
      lane_lst[k] = lst_pipe_q[k-1];
      lane_dat[k] = dat_pipe_q[k-1];
    end
  end

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge sys_clk) begin
    if (cap_vld_q) buf_q[cap_idx_q] <= main_mem_data_out;
    if (state_q == LOAD_H && cell_valid_in) buf_q[IDX_W'(X_LEN) + hcnt_q] <= cell_out_data_in;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      oe_q        <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_idx_q   <= '0;
      fcnt_q      <= '0;
      hcnt_q      <= '0;
      e_q         <= '0;
      pcnt_q      <= '0;
      passes_q    <= '0;
      loaded_q    <= 1'b0;
      load_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      done_q      <= 1'b0;
      issue_q     <= 1'b0;
      vld_pipe_q  <= '0;
      lst_pipe_q  <= '0;
      dat_pipe_q  <= '0;
    end else begin
      load_done_q <= 1'b0;
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      cap_vld_q   <= oe_q;
      cap_idx_q   <= fcnt_q;
      for (int k = 0; k < P-1; k++) begin
        vld_pipe_q[k] <= lane_vld[k];
        lst_pipe_q[k] <= lane_lst[k];
        dat_pipe_q[k] <= lane_dat[k];
      end
      case (state_q)
        IDLE: begin
          cmd_err_q <= start & (load | ~loaded_q);
          if (load) begin
            addr_q   <= x_base_addr;
            oe_q     <= 1'b1;
            fcnt_q   <= '0;
            loaded_q <= 1'b0;
            state_q  <= FETCH;
          end else if (start && loaded_q) begin
            passes_q <= passes_d;
            pcnt_q   <= '0;
            e_q      <= '0;
            issue_q  <= 1'b1;
            state_q  <= STREAM;
          end
        end
        FETCH: begin
          cmd_err_q <= load | start;
          // One extra cycle after the last issue lets the final read land in the buffer.
          if (oe_q) begin
            if (fcnt_q == IDX_W'(X_LEN-1)) oe_q <= 1'b0;
            else begin
              addr_q <= addr_q + 1'b1;
              fcnt_q <= fcnt_q + 1'b1;
            end
          end else begin
            hcnt_q  <= '0;
            state_q <= LOAD_H;
          end
        end
        LOAD_H: begin
          cmd_err_q <= load | start;
          if (cell_valid_in) begin
            if (hcnt_q == IDX_W'(H_LEN-1)) begin
              loaded_q    <= 1'b1;
              load_done_q <= 1'b1;
              state_q     <= IDLE;
            end else hcnt_q <= hcnt_q + 1'b1;
          end
        end
        STREAM: begin
          cmd_err_q <= load | start;
          if (issue_q) begin
            if (e_q == IDX_W'(VEC_LEN-1)) begin
              e_q <= '0;
              if (pcnt_q == passes_q - PASS_BITS'(1)) issue_q <= 1'b0;
              else pcnt_q <= pcnt_q + 1'b1;
            end else e_q <= e_q + 1'b1;
          end
          if (lane_lst[P-1]) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign main_mem_address_out = addr_q;
  assign main_mem_oe_out      = oe_q;
  assign load_done            = load_done_q;
  assign cmd_err              = cmd_err_q;
  assign stream_done          = done_q;
  assign busy                 = (state_q != IDLE);
  assign pe_valid_out         = lane_vld;
  assign pe_data_out          = lane_dat;
endmodule

// File: tb/tb_input_stream_feeder.sv
// Directed bench for input_stream_feeder: load, multi-pass skewed streaming,
// illegal commands, address wrap and mid-stream reset.
module tb_input_stream_feeder;
  localparam int P  = 4;
  localparam int VL = 8;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1, load = 1'b0, start = 1'b0, cell_valid_in = 1'b0;
  logic [3:0]  x_base_addr = '0, num_passes = '0;
  logic [7:0]  cell_out_data_in = '0, main_mem_data_out;
  logic [3:0]  main_mem_address_out;
  logic        main_mem_oe_out, load_done, busy, stream_done, cmd_err;
  logic [P*8-1:0] pe_data_out;
  logic [P-1:0]   pe_valid_out;

  int errs = 0, checks = 0;
  logic [7:0] mem [16];
  logic [7:0] exp_buf [VL];

  input_stream_feeder #(.ELEMENT_BITS(8), .X_LEN(4), .H_LEN(4), .P(P),
                        .ADDR_BITS(4), .PASS_BITS(4)) dut (
    .sys_clk(sys_clk), .reset(reset), .load(load), .x_base_addr(x_base_addr),
    .main_mem_address_out(main_mem_address_out), .main_mem_oe_out(main_mem_oe_out),
    .main_mem_data_out(main_mem_data_out), .cell_valid_in(cell_valid_in),
    .cell_out_data_in(cell_out_data_in), .load_done(load_done), .start(start),
    .num_passes(num_passes), .pe_data_out(pe_data_out), .pe_valid_out(pe_valid_out),
    .busy(busy), .stream_done(stream_done), .cmd_err(cmd_err));

  always #5 sys_clk = ~sys_clk;

  // Main memory with one cycle of read latency.
  always @(posedge sys_clk) if (main_mem_oe_out) main_mem_data_out <= mem[main_mem_address_out];

  task automatic step;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step; step;
    checks++;
    if ({pe_valid_out, pe_data_out} !== '0) begin
      errs++; $display("FAIL reset_lanes: got v=%b d=%h want 0", pe_valid_out, pe_data_out);
    end
    checks++;
    if ({busy, stream_done, cmd_err, load_done, main_mem_oe_out, main_mem_address_out} !== '0) begin
      errs++; $display("FAIL reset_ctrl: got busy=%b done=%b err=%b ld=%b oe=%b addr=%h want 0",
                       busy, stream_done, cmd_err, load_done, main_mem_oe_out, main_mem_address_out);
    end
    reset = 1'b0;
    step;
  endtask

  task automatic test_start_unloaded;
    start = 1'b1; step; start = 1'b0;
    checks++;
    if (cmd_err !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL start_unloaded: got err=%b busy=%b want err=1 busy=0", cmd_err, busy);
    end
    step;
    checks++;
    if (cmd_err !== 1'b0) begin
      errs++; $display("FAIL err_one_cycle: got err=%b want 0", cmd_err);
    end
  endtask

  task automatic test_load(input logic [3:0] base, input logic [31:0] hv,
                           input bit noise, input bit with_start);
    int pulses;
    logic [3:0] ea;
    x_base_addr = base; load = 1'b1; start = with_start;
    step;
    load = 1'b0; start = 1'b0; x_base_addr = 4'h0;
    checks++;
    if (cmd_err !== with_start) begin
      errs++; $display("FAIL load_start_err: got %b want %b", cmd_err, with_start);
    end
    for (int i = 0; i < 4; i++) begin
      ea = base + 4'(i);
      checks++;
      if (main_mem_oe_out !== 1'b1 || main_mem_address_out !== ea) begin
        errs++; $display("FAIL fetch_addr%0d: got oe=%b addr=%0d want oe=1 addr=%0d",
                         i, main_mem_oe_out, main_mem_address_out, ea);
      end
      cell_valid_in = noise; cell_out_data_in = 8'hEE;
      step;
    end
    cell_valid_in = 1'b0;
    checks++;
    if (main_mem_oe_out !== 1'b0) begin
      errs++; $display("FAIL fetch_oe_drop: got oe=%b want 0", main_mem_oe_out);
    end
    step;
    pulses = 0;
    for (int j = 0; j < 4; j++) begin
      cell_valid_in = 1'b1; cell_out_data_in = hv[j*8 +: 8];
      step;
      cell_valid_in = 1'b0;
      if (load_done) pulses++;
      if (j == 1) begin
        step;
        if (load_done) pulses++;
      end
    end
    checks++;
    if (load_done !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL load_done_timing: got ld=%b busy=%b want ld=1 busy=0", load_done, busy);
    end
    step;
    if (load_done) pulses++;
    checks++;
    if (pulses != 1) begin
      errs++; $display("FAIL load_done_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_stream(input logic [3:0] np, input int passes, input bit inject);
    int n, idx;
    logic [P-1:0]   ev;
    logic [P*8-1:0] ed;
    n = passes * VL;
    num_passes = np; start = 1'b1;
    step;
    start = 1'b0; num_passes = 4'h0;
    for (int c = 1; c <= n + P; c++) begin
      ev = '0; ed = '0;
      for (int k = 0; k < P; k++) begin
        idx = c - k;
        if (idx >= 1 && idx <= n) begin
          ev[k] = 1'b1;
          ed[k*8 +: 8] = exp_buf[(idx-1) % VL];
        end
      end
      checks++;
      if (pe_valid_out !== ev || pe_data_out !== ed) begin
        errs++; $display("FAIL stream_lanes c=%0d: got v=%b d=%h want v=%b d=%h",
                         c, pe_valid_out, pe_data_out, ev, ed);
      end
      checks++;
      if (stream_done !== (c == n + P) || busy !== (c < n + P) ||
          cmd_err !== (inject && (c == 4 || c == 7))) begin
        errs++; $display("FAIL stream_ctrl c=%0d: got done=%b busy=%b err=%b want done=%b busy=%b err=%b",
                         c, stream_done, busy, cmd_err, c == n + P, c < n + P,
                         inject && (c == 4 || c == 7));
      end
      load  = inject && (c == 3);
      start = inject && (c == 6);
      step;
      load = 1'b0; start = 1'b0;
    end
    checks++;
    if (pe_valid_out !== '0 || stream_done !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL stream_end: got v=%b done=%b busy=%b want 0", pe_valid_out, stream_done, busy);
    end
  endtask

  task automatic test_reset_mid;
    bit bad;
    num_passes = 4'h1; start = 1'b1;
    step;
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (pe_valid_out[0] !== 1'b1 || pe_data_out[7:0] !== exp_buf[c-1]) begin
        errs++; $display("FAIL pre_reset_lane0 c=%0d: got v=%b d=%h want v=1 d=%h",
                         c, pe_valid_out[0], pe_data_out[7:0], exp_buf[c-1]);
      end
      if (c < 5) step;
    end
    reset = 1'b1;
    step;
    reset = 1'b0;
    checks++;
    if (pe_valid_out !== '0 || pe_data_out !== '0 || busy !== 1'b0 || stream_done !== 1'b0) begin
      errs++; $display("FAIL reset_abort: got v=%b d=%h busy=%b done=%b want 0",
                       pe_valid_out, pe_data_out, busy, stream_done);
    end
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step;
      if (stream_done !== 1'b0 || pe_valid_out !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errs++; $display("FAIL reset_quiet: got activity after abort want none");
    end
    start = 1'b1; step; start = 1'b0;
    checks++;
    if (cmd_err !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL reset_cleared_loaded: got err=%b busy=%b want err=1 busy=0", cmd_err, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
    mem[0] = 8'd5; mem[1] = 8'd6; mem[2] = 8'd7; mem[3] = 8'd8;
    mem[14] = 8'h21; mem[15] = 8'h22;

    test_reset;
    test_start_unloaded;

    test_load(4'd0, 32'h04030201, 1'b0, 1'b0);
    exp_buf = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd1, 8'd2, 8'd3, 8'd4};
    test_stream(4'd1, 1, 1'b0);
    test_stream(4'd2, 2, 1'b0);
    test_stream(4'd0, 1, 1'b0);
    test_stream(4'd1, 1, 1'b1);

    test_load(4'd14, 32'h0C0B0A09, 1'b1, 1'b1);
    exp_buf = '{8'h21, 8'h22, 8'd5, 8'd6, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    test_stream(4'd1, 1, 1'b0);

    test_reset_mid;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
